// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-index width and hazard controller FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Width of an architectural register index (32 registers).
  localparam int REG_W = 5;

  // Hazard controller FSM states; encoding 3 is unused and must not be held.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, never wraps.
// Latency: count updates on the edge after inc; clear is synchronous and wins over inc.
// Backpressure: none, one increment per cycle at most.
//
// Ports:
//   clk   - rising-edge clock
//   clear - synchronous clear to zero
//   inc   - add one this edge unless already saturated
//   count - current count
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use and branch-data hazards, stalls or flushes IF/ID.
// Latency: enables are combinational from state and inputs (zero cycles); state/counters update next edge.
// Backpressure: a hazard holds PC and IF/ID and bubbles ID/EX for one cycle, re-stalling while a hazard persists.
//
// Ports:
//   clk_i, rst_i           - clock, synchronous active-high reset
//   start_i                - run enable; low returns to / holds IDLE
//   id_rs1_i, id_rs2_i     - source registers of the instruction in ID
//   id_branch_i            - ID holds a conditional branch
//   branch_taken_i         - branch comparison in ID is true
//   ex_memread_i           - EX holds a load
//   ex_regwrite_i          - EX writes a register
//   ex_rd_i                - destination register of EX
//   pc_write_o             - PC update enable
//   ifid_write_o           - IF/ID write enable
//   idex_bubble_o          - zero ID/EX control fields this cycle
//   ifid_flush_o           - load a NOP into IF/ID this cycle
//   pc_sel_o               - next PC comes from the branch target
//   stall_cnt_o            - saturating count of non-branch stall cycles
//   flush_cnt_o            - saturating count of flush cycles
//   state_o                - current FSM state for debug
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_branch_i,
  input  logic             branch_taken_i,
  input  logic             ex_memread_i,
  input  logic             ex_regwrite_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic             ifid_flush_o,
  output logic             pc_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  hz_state_e state_q;
  hz_state_e state_d;

  logic rd_match;
  logic hz;
  logic stall_inc;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  assign rd_match = (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  // A branch resolved in ID needs its operands one stage earlier than an ALU
  // op, so any register-writing EX producer forces a wait, not just a load.
  assign hz = rd_match && (ex_memread_i || (id_branch_i && ex_regwrite_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = ST_IDLE;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_bubble_o = 1'b1;
    ifid_flush_o  = 1'b0;
    pc_sel_o      = 1'b0;
    stall_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end
      end

      // STALL behaves like RUN; it only exists so a stall is visible for one
      // cycle and a follow-on hazard naturally re-enters it.
      ST_RUN, ST_STALL: begin
        if (start_i) begin
          if (hz) begin
            // Hazard outranks a taken branch: the branch resolves once the
            // operand is available, so no redirect/flush this cycle.
            state_d   = ST_STALL;
            stall_inc = !id_branch_i;
          end else begin
            state_d       = ST_RUN;
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            idex_bubble_o = 1'b0;
            ifid_flush_o  = id_branch_i && branch_taken_i;
            pc_sel_o      = id_branch_i && branch_taken_i;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Hold the pipeline quiet for the whole reset cycle, whatever state is held.
    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      ifid_flush_o  = 1'b0;
      pc_sel_o      = 1'b0;
      stall_inc     = 1'b0;
    end
  end

  assign state_o = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clear (rst_i),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .clear (rst_i),
    .inc   (ifid_flush_o),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Two instances share the stimulus: default 32-bit counters and 4-bit counters for saturation.
// Outputs are sampled 1 time unit after inputs change, well away from the rising edge.
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] id_rs1_i = '0;
  logic [4:0] id_rs2_i = '0;
  logic       id_branch_i = 1'b0;
  logic       branch_taken_i = 1'b0;
  logic       ex_memread_i = 1'b0;
  logic       ex_regwrite_i = 1'b0;
  logic [4:0] ex_rd_i = '0;

  logic        pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, pc_sel_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  logic [1:0]  state_o;

  logic        pc_write4, ifid_write4, idex_bubble4, ifid_flush4, pc_sel4;
  logic [3:0]  stall_cnt4, flush_cnt4;
  logic [1:0]  state4;

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_branch_i(id_branch_i), .branch_taken_i(branch_taken_i),
    .ex_memread_i(ex_memread_i), .ex_regwrite_i(ex_regwrite_i), .ex_rd_i(ex_rd_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .idex_bubble_o(idex_bubble_o), .ifid_flush_o(ifid_flush_o), .pc_sel_o(pc_sel_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .state_o(state_o)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_branch_i(id_branch_i), .branch_taken_i(branch_taken_i),
    .ex_memread_i(ex_memread_i), .ex_regwrite_i(ex_regwrite_i), .ex_rd_i(ex_rd_i),
    .pc_write_o(pc_write4), .ifid_write_o(ifid_write4),
    .idex_bubble_o(idex_bubble4), .ifid_flush_o(ifid_flush4), .pc_sel_o(pc_sel4),
    .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4), .state_o(state4)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pipeline mode (0 idle, 1 running, 2 stalled) and event tallies.
  int              m_mode = 0;
  longint unsigned m_stall = 0;
  longint unsigned m_flush = 0;

  // Last sampled outputs, for directed checks after a step.
  logic obs_pcw, obs_bub, obs_flush, obs_sel;

  function automatic longint unsigned sat(input longint unsigned v, input int w);
    longint unsigned lim;
    lim = (64'd1 << w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

  // One clock cycle: apply inputs, check outputs against the model, advance model across the edge.
  task automatic step(input logic rst, input logic start, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic br, input logic tk, input logic mr, input logic rw, input logic [4:0] rd);
    logic running, dep, hazard, e_pcw, e_bub, e_fl;
    rst_i = rst; start_i = start; id_rs1_i = rs1; id_rs2_i = rs2;
    id_branch_i = br; branch_taken_i = tk; ex_memread_i = mr; ex_regwrite_i = rw; ex_rd_i = rd;
    #1;
    running = !rst && start && (m_mode != 0);
    dep     = (rd != 0) && (rd == rs1 || rd == rs2);
    hazard  = dep && (mr || (br && rw));
    e_pcw   = running && !hazard;
    e_bub   = !e_pcw;
    e_fl    = e_pcw && br && tk;

    chk("pc_write",    {63'd0, pc_write_o},    {63'd0, e_pcw});
    chk("ifid_write",  {63'd0, ifid_write_o},  {63'd0, e_pcw});
    chk("idex_bubble", {63'd0, idex_bubble_o}, {63'd0, e_bub});
    chk("ifid_flush",  {63'd0, ifid_flush_o},  {63'd0, e_fl});
    chk("pc_sel",      {63'd0, pc_sel_o},      {63'd0, e_fl});
    chk("state",       {62'd0, state_o},       m_mode);
    chk("stall_cnt",   {32'd0, stall_cnt_o},   sat(m_stall, 32));
    chk("flush_cnt",   {32'd0, flush_cnt_o},   sat(m_flush, 32));
    chk("stall_cnt4",  {60'd0, stall_cnt4},    sat(m_stall, 4));
    chk("flush_cnt4",  {60'd0, flush_cnt4},    sat(m_flush, 4));
    chk("pc_write4",   {63'd0, pc_write4},     {63'd0, e_pcw});
    chk("ifid_flush4", {63'd0, ifid_flush4},   {63'd0, e_fl});

    obs_pcw = pc_write_o; obs_bub = idex_bubble_o; obs_flush = ifid_flush_o; obs_sel = pc_sel_o;

    if (rst) begin
      m_mode = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (running && hazard && !br) m_stall++;
      if (e_fl) m_flush++;
      if (m_mode == 0) m_mode = start ? 1 : 0;
      else if (!start)  m_mode = 0;
      else              m_mode = hazard ? 2 : 1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pcw_c1", {63'd0, obs_pcw}, 64'd0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pcw_c2", {63'd0, obs_pcw}, 64'd0);
    chk("rst_state", {62'd0, state_o}, 64'd0);
    chk("rst_stall", {32'd0, stall_cnt_o}, 64'd0);
    chk("rst_flush", {32'd0, flush_cnt_o}, 64'd0);
  endtask

  task automatic idle_step();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk_i);
    #1;

    // Reset with start held high.
    do_reset();
    chk("post_rst_bubble", {63'd0, idex_bubble_o}, 64'd1);

    // Load-use: load r5 in EX, rs1=5 in ID.
    idle_step();                                   // IDLE -> RUN
    chk("run_state", {62'd0, state_o}, 64'd1);
    step(0, 1, 5, 9, 0, 0, 1, 1, 5);
    chk("lu_pcw", {63'd0, obs_pcw}, 64'd0);
    chk("lu_bubble", {63'd0, obs_bub}, 64'd1);
    chk("lu_state_stall", {62'd0, state_o}, 64'd2);
    step(0, 1, 5, 9, 0, 0, 0, 0, 0);               // bubble now in EX
    chk("lu_resume_pcw", {63'd0, obs_pcw}, 64'd1);
    chk("lu_stall_cnt", {32'd0, stall_cnt_o}, 64'd1);
    chk("lu_back_run", {62'd0, state_o}, 64'd1);

    // Taken branch, no hazard.
    do_reset();
    idle_step();
    step(0, 1, 3, 4, 1, 1, 0, 1, 6);
    chk("br_sel", {63'd0, obs_sel}, 64'd1);
    chk("br_flush", {63'd0, obs_flush}, 64'd1);
    chk("br_flush_cnt", {32'd0, flush_cnt_o}, 64'd1);
    idle_step();
    chk("br_one_cycle", {63'd0, obs_flush}, 64'd0);

    // Branch depends on a load: stall (not counted), then flush.
    do_reset();
    idle_step();
    step(0, 1, 7, 0, 1, 1, 1, 1, 7);
    chk("bd_no_flush", {63'd0, obs_flush}, 64'd0);
    chk("bd_no_sel", {63'd0, obs_sel}, 64'd0);
    chk("bd_stall_cnt", {32'd0, stall_cnt_o}, 64'd0);
    step(0, 1, 7, 0, 1, 1, 0, 0, 0);
    chk("bd_flush", {63'd0, obs_flush}, 64'd1);
    chk("bd_flush_cnt", {32'd0, flush_cnt_o}, 64'd1);

    // x0 destination never stalls.
    step(0, 1, 0, 0, 0, 0, 1, 1, 0);
    chk("x0_pcw", {63'd0, obs_pcw}, 64'd1);

    // start_i drop returns to IDLE, counters hold.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stop_idle", {62'd0, state_o}, 64'd0);
    chk("stop_flush_hold", {32'd0, flush_cnt_o}, 64'd1);

    // 20 back-to-back load-use hazards: 4-bit counter saturates at 15.
    do_reset();
    idle_step();
    for (int i = 0; i < 20; i++) step(0, 1, 0, 12, 0, 0, 1, 0, 12);
    chk("sat_stall4", {60'd0, stall_cnt4}, 64'd15);
    chk("sat_stall32", {32'd0, stall_cnt_o}, 64'd20);

    // Randomized traffic with small register pool so dependencies are common.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 15) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the stall and flush performance counters.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  pipeline run enable; low holds the pipeline idle.
REQ-005 id_rs1_i, id_rs2_i  input  5 each  source registers of the instruction in ID.
REQ-006 id_branch_i  input  1  the instruction in ID is a conditional branch (resolved in ID).
REQ-007 branch_taken_i  input  1  the branch comparison in ID is true.
REQ-008 ex_memread_i, ex_regwrite_i  input  1 each  the instruction in EX is a load / writes a register.
REQ-009 ex_rd_i  input  5  destination register of the instruction in EX.
REQ-010 pc_write_o  output  1  PC update enable.
REQ-011 ifid_write_o  output  1  IF/ID register write enable.
REQ-012 idex_bubble_o  output  1  zero the control fields written into ID/EX this cycle.
REQ-013 ifid_flush_o  output  1  write a NOP into IF/ID this cycle.
REQ-014 pc_sel_o  output  1  1 selects the branch target for the next PC.
REQ-015 stall_cnt_o, flush_cnt_o  output  CNT_W each  count of stall cycles and flush cycles.
REQ-016 state_o  output  2  current FSM state, for debug.

Function
REQ-017 FSM states: IDLE=0, RUN=1, STALL=2; encoding 3 is unreachable and SHALL return to IDLE on the next edge.
REQ-018 IDLE: all enables low, bubble high, no counting; go to RUN on the first edge with start_i=1.
REQ-019 start_i falling in RUN or STALL SHALL return the FSM to IDLE on the next edge; counters hold their values.
REQ-020 A hazard match SHALL require ex_rd_i!=0 and (ex_rd_i==id_rs1_i or ex_rd_i==id_rs2_i).
REQ-021 The load-use condition is ex_memread_i=1 with a hazard match.
REQ-022 The branch-data condition is id_branch_i=1, ex_regwrite_i=1 and a hazard match.
REQ-023 In RUN with either condition true (hz): pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, pc_sel_o=0; go to STALL next edge.
REQ-024 hz SHALL take priority over a taken branch in the same cycle: no flush, no redirect, flush counter unchanged.
REQ-025 In RUN without hz: pc_write_o=1, ifid_write_o=1, idex_bubble_o=0; if id_branch_i and branch_taken_i then pc_sel_o=1 and ifid_flush_o=1, else both 0.
REQ-026 STALL lasts exactly one cycle; outputs are combinational from the current inputs as in RUN, so a second hazard (e.g. load followed by a dependent branch) SHALL re-stall; next state is STALL if hz, else RUN.
REQ-027 Outputs SHALL be combinational functions of state and inputs, with zero latency from inputs to enables.
REQ-028 stall_cnt increments by 1 on each edge where the FSM is in RUN or STALL with hz true and id_branch_i=0.
REQ-029 flush_cnt increments by 1 on each edge where ifid_flush_o=1.
REQ-030 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-031 On an edge with rst_i=1: state=IDLE and both counters=0, regardless of start_i or a stall in progress.
REQ-032 During and immediately after reset: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, pc_sel_o=0, state_o=0.

Structure
REQ-033 The state encoding and the register-index width (5) SHALL be defined in the shared package cpu_pkg.
REQ-034 A single sub-module, sat_counter (parameter CNT_W; inputs inc and clear), SHALL be instantiated once for each counter.

Verification
REQ-035 Reset with start_i=1 and rst_i=1 for 2 cycles -> state_o=0, counters=0 and pc_write_o=0 throughout.
REQ-036 Run, then a load with ex_rd=5 in EX while rs1=5 in ID -> exactly one cycle with pc_write_o=0 and idex_bubble_o=1, stall_cnt=1, then RUN.
REQ-037 Taken branch in ID with no hazard -> pc_sel_o=1 and ifid_flush_o=1 for one cycle, flush_cnt=1.
REQ-038 Branch with rs1=7 in ID while EX is a load with rd=7 -> a stall cycle (stall_cnt unchanged because id_branch_i=1), then the flush resolves -> flush_cnt=1.
REQ-039 ex_rd_i=0 with ex_memread_i=1 and rs1=0 -> no stall.
REQ-040 With CNT_W=4, force 20 back-to-back load-use hazards -> stall_cnt holds at 15.
